// File: rtl/containment_classifier.sv
// Containment status classifier: filters the containment-field reading and
// the door / operator-alarm inputs into a GREEN / YELLOW / RED status with
// fast, filtered escalation and slow, step-wise de-escalation with hysteresis.
module containment_classifier #(
  parameter logic [7:0]  YEL_TH    = 8'd100,
  parameter logic [7:0]  RED_TH    = 8'd200,
  parameter logic [7:0]  HYST      = 8'd16,
  parameter int unsigned ESC_CYC   = 2,
  parameter int unsigned DEESC_CYC = 5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] sensor_level,
  input  logic       door_open,
  input  logic       manual_alarm,
  output logic       green,
  output logic       yellow,
  output logic       red,
  output logic [1:0] level,
  output logic       changed
);

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_RED    = 2'd2
  } state_e;

  // De-escalation thresholds sit HYST below the escalation thresholds so a
  // reading inside the band holds whatever state we are already in.
  localparam logic [7:0] RED_DN_TH  = RED_TH - HYST;
  localparam logic [7:0] YEL_DN_TH  = YEL_TH - HYST;
  localparam logic [2:0] ESC_LAST   = 3'(ESC_CYC - 1);
  localparam logic [3:0] DEESC_LAST = 4'(DEESC_CYC - 1);

  state_e     state_q, state_d;
  logic [2:0] esc_cnt_q, esc_cnt_d;
  logic [3:0] deesc_cnt_q, deesc_cnt_d;
  logic       changed_q, changed_d;
  state_e     up_tgt, down_tgt;

  // Targets the inputs would justify, with and without hysteresis.
  always_comb begin
    if (manual_alarm || sensor_level >= RED_TH)         up_tgt = ST_RED;
    else if (door_open || sensor_level >= YEL_TH)       up_tgt = ST_YELLOW;
    else                                                up_tgt = ST_GREEN;

    if (manual_alarm || sensor_level >= RED_DN_TH)      down_tgt = ST_RED;
    else if (door_open || sensor_level >= YEL_DN_TH)    down_tgt = ST_YELLOW;
    else                                                down_tgt = ST_GREEN;
  end

  // Next-state and counter update: alarm override, filtered escalation,
  // one-step-at-a-time de-escalation, otherwise hold and clear the filters.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d     = state_q;
    esc_cnt_d   = '0;
    deesc_cnt_d = '0;

    if (manual_alarm) begin
      state_d = ST_RED;
    end else if (up_tgt > state_q) begin
      if (esc_cnt_q >= ESC_LAST) begin
        state_d = up_tgt;
      end else begin
        esc_cnt_d = esc_cnt_q + 3'd1;
      end
    end else if (down_tgt < state_q) begin
      if (deesc_cnt_q >= DEESC_LAST) begin
        state_d = (state_q == ST_RED) ? ST_YELLOW : ST_GREEN;
      end else begin
        deesc_cnt_d = deesc_cnt_q + 4'd1;
      end
    end

    changed_d = (state_d != state_q);
  end

  // State, filter counters and change pulse; reset lands in GREEN.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_GREEN;
      esc_cnt_q   <= '0;
      deesc_cnt_q <= '0;
      changed_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q     <= state_d;
      esc_cnt_q   <= esc_cnt_d;
      deesc_cnt_q <= deesc_cnt_d;
      changed_q   <= changed_d;
    end
  end

  assign green   = (state_q == ST_GREEN);
  assign yellow  = (state_q == ST_YELLOW);
  assign red     = (state_q == ST_RED);
  assign level   = state_q;
  assign changed = changed_q;

endmodule
